// File: rtl/adc_fifo_drain.sv
// Round-robin drain of per-channel ADC sample FIFOs onto a tagged valid/ready word stream.
// Keeps one sample in flight at most and records sticky per-channel FIFO overflow.
module adc_fifo_drain #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int BURST_LEN    = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            enable,
    input  logic                            clear_ovf,
    output logic [$clog2(NUM_CHANNELS)-1:0] fifo_addr,
    output logic [NUM_CHANNELS-1:0]         fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]           fifo_dout,
    input  logic                            fifo_not_empty,
    input  logic                            fifo_full,
    output logic [31:0]                     m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [NUM_CHANNELS-1:0]         ovf_flags
);

    localparam int PTR_W = $clog2(NUM_CHANNELS);
    localparam int BC_W  = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_READ,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t                  r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_addr;
    logic [BC_W-1:0]         r_burst;
    logic [7:0]              r_seq [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_rd_en;
    logic [NUM_CHANNELS-1:0] r_ovf;
    logic [31:0]             r_tdata;
    logic                    r_tvalid;
    logic [NUM_CHANNELS-1:0] w_ovf_set;
    logic                    w_more;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_CHANNELS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [NUM_CHANNELS-1:0] onehot(input logic [PTR_W-1:0] p);
        return NUM_CHANNELS'(1) << p;
    endfunction

    // Stay on the channel only while it still has data and the burst quota is not used up
    assign w_more = enable && fifo_not_empty && (r_burst < BC_W'(BURST_LEN));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_addr   <= '0;
            r_burst  <= '0;
            r_rd_en  <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_seq[i] <= '0;
            end
        end else begin
            r_rd_en <= '0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_addr  <= r_ptr;
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (fifo_not_empty) begin
                        r_rd_en <= onehot(r_ptr);
                        r_state <= S_READ;
                    end else begin
                        r_ptr  <= next_ptr(r_ptr);
                        r_addr <= next_ptr(r_ptr);
                    end
                end
                S_READ: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_tdata       <= {8'(r_ptr), r_seq[r_ptr], 16'(fifo_dout)};
                    r_tvalid      <= 1'b1;
                    r_seq[r_ptr]  <= r_seq[r_ptr] + 8'd1;
                    r_burst       <= r_burst + BC_W'(1);
                    r_state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_tvalid && m_tready) begin
                        r_tvalid <= 1'b0;
                        if (w_more) begin
                            r_rd_en <= onehot(r_ptr);
                            r_state <= S_READ;
                        end else begin
                            r_burst <= '0;
                            r_ptr   <= next_ptr(r_ptr);
                            r_addr  <= next_ptr(r_ptr);
                            r_state <= enable ? S_SELECT : S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A set in the same cycle as a clear takes priority so no overflow event is lost
    assign w_ovf_set = (r_state != S_IDLE && fifo_full) ? onehot(r_addr) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~{NUM_CHANNELS{clear_ovf}}) | w_ovf_set;
        end
    end

    assign fifo_addr  = r_addr;
    assign fifo_rd_en = r_rd_en;
    assign m_tdata    = r_tdata;
    assign m_tvalid   = r_tvalid;
    assign ovf_flags  = r_ovf;

endmodule

// File: tb/tb_adc_fifo_drain.sv
// Bench for adc_fifo_drain: behavioural per-channel FIFOs, output monitor and expected-word scoreboard.
module tb_adc_fifo_drain;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        clear_ovf;
    logic [1:0]  fifo_addr;
    logic [3:0]  fifo_rd_en;
    logic [11:0] fifo_dout;
    logic        fifo_not_empty;
    logic        fifo_full;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [3:0]  ovf_flags;

    adc_fifo_drain #(
        .NUM_CHANNELS(4),
        .DATA_WIDTH(12),
        .BURST_LEN(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .enable(enable),
        .clear_ovf(clear_ovf),
        .fifo_addr(fifo_addr),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout),
        .fifo_not_empty(fifo_not_empty),
        .fifo_full(fifo_full),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .ovf_flags(ovf_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFOs: written by the stimulus, popped by the DUT's read strobes
    logic [11:0] mem [4][512];
    int          wrp [4];
    int          rdp [4];
    logic [3:0]  full_vec;
    int          rd_pulses;
    int          underflows;
    int          multi_hot;

    assign fifo_not_empty = (wrp[fifo_addr] != rdp[fifo_addr]);
    assign fifo_full      = full_vec[fifo_addr];

    always @(posedge clk) begin
        if (fifo_rd_en != 4'b0) rd_pulses <= rd_pulses + 1;
        if ($countones(fifo_rd_en) > 1) multi_hot <= multi_hot + 1;
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd_en[i]) begin
                if (rdp[i] != wrp[i]) begin
                    fifo_dout <= mem[i][rdp[i] % 512];
                    rdp[i]    <= rdp[i] + 1;
                end else begin
                    underflows <= underflows + 1;
                end
            end
        end
    end

    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];
    logic [7:0]  tb_seq [4];
    int          checks;
    int          errors;

    always @(negedge clk) begin
        if (rstn && m_tvalid && m_tready) obs_q.push_back(m_tdata);
    end

    task automatic load(input int ch, input logic [11:0] v);
        mem[ch][wrp[ch] % 512] = v;
        wrp[ch] = wrp[ch] + 1;
    endtask

    task automatic push_exp(input int ch, input logic [11:0] v);
        exp_q.push_back({8'(ch), tb_seq[ch], 4'h0, v});
        tb_seq[ch] = tb_seq[ch] + 8'd1;
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        enable    = 1'b0;
        clear_ovf = 1'b0;
        m_tready  = 1'b0;
        full_vec  = 4'b0;
        cyc(2);
        for (int i = 0; i < 4; i++) tb_seq[i] = 8'd0;
        obs_q.delete();
        exp_q.delete();
        rstn = 1'b1;
        cyc(1);
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (obs_q.size() < n && c < budget) begin
            cyc(1);
            c++;
        end
    endtask

    task automatic compare_words(input string name, input int n);
        logic [31:0] got;
        logic [31:0] want;
        checks++;
        if (obs_q.size() !== n) begin
            errors++;
            $display("FAIL %s_count: got %0d words, want %0d", name, obs_q.size(), n);
        end
        for (int k = 0; k < n; k++) begin
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAAD_F00D;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s_word%0d: got %08h, want %08h", name, k, got, want);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cyc(2);
        checks++;
        if ({fifo_addr, fifo_rd_en, m_tvalid, ovf_flags} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got addr=%0d rd_en=%b tvalid=%b ovf=%b, want all 0",
                     fifo_addr, fifo_rd_en, m_tvalid, ovf_flags);
        end
        checks++;
        if (m_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_tdata: got %08h, want 00000000", m_tdata);
        end
        do_reset();
        checks++;
        if (m_tvalid !== 1'b0 || fifo_rd_en !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: got tvalid=%b rd_en=%b, want 0/0000", m_tvalid, fifo_rd_en);
        end
    endtask

    task automatic test_single_channel();
        logic [1:0] a [4];
        do_reset();
        load(0, 12'h123);
        load(0, 12'h456);
        load(0, 12'h789);
        exp_q.push_back(32'h0000_0123);
        exp_q.push_back(32'h0001_0456);
        exp_q.push_back(32'h0002_0789);
        m_tready = 1'b1;
        enable   = 1'b1;
        wait_words(3, 100);
        a[0] = fifo_addr;
        for (int k = 1; k < 4; k++) begin
            cyc(1);
            a[k] = fifo_addr;
        end
        checks++;
        if ({a[0], a[1], a[2], a[3]} !== {2'd1, 2'd2, 2'd3, 2'd0}) begin
            errors++;
            $display("FAIL single_rr_walk: got %0d,%0d,%0d,%0d, want 1,2,3,0", a[0], a[1], a[2], a[3]);
        end
        compare_words("single", 3);
        enable = 1'b0;
        cyc(3);
    endtask

    task automatic test_burst();
        do_reset();
        for (int ch = 0; ch < 4; ch++)
            for (int i = 0; i < 20; i++) load(ch, 12'((ch << 8) | i));
        for (int ch = 0; ch < 4; ch++)
            for (int i = 0; i < 16; i++) push_exp(ch, 12'((ch << 8) | i));
        for (int ch = 0; ch < 4; ch++)
            for (int i = 16; i < 20; i++) push_exp(ch, 12'((ch << 8) | i));
        m_tready = 1'b1;
        enable   = 1'b1;
        wait_words(80, 600);
        compare_words("burst", 80);
        checks++;
        if (underflows !== 0 || multi_hot !== 0) begin
            errors++;
            $display("FAIL burst_rd_en: got underflows=%0d multi_hot=%0d, want 0/0", underflows, multi_hot);
        end
        enable = 1'b0;
        cyc(3);
    endtask

    task automatic test_back_pressure();
        logic [31:0] d0;
        int          p0;
        int          unstable;
        int          c;
        do_reset();
        load(1, 12'hABC);
        load(1, 12'h0DE);
        push_exp(1, 12'hABC);
        push_exp(1, 12'h0DE);
        enable = 1'b1;
        c = 0;
        while (!m_tvalid && c < 30) begin
            cyc(1);
            c++;
        end
        d0 = m_tdata;
        p0 = rd_pulses;
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (m_tdata !== d0 || m_tvalid !== 1'b1) unstable++;
        end
        checks++;
        if (m_tvalid !== 1'b1 || unstable !== 0) begin
            errors++;
            $display("FAIL hold_stable: got tvalid=%b unstable_cycles=%0d, want 1/0", m_tvalid, unstable);
        end
        checks++;
        if (rd_pulses !== p0) begin
            errors++;
            $display("FAIL hold_no_pop: got %0d rd_en pulses, want %0d", rd_pulses, p0);
        end
        m_tready = 1'b1;
        wait_words(2, 50);
        compare_words("hold", 2);
        enable = 1'b0;
        cyc(3);
    endtask

    task automatic test_enable_drop();
        int p0;
        int c;
        do_reset();
        load(2, 12'h111);
        load(2, 12'h222);
        load(2, 12'h333);
        push_exp(2, 12'h111);
        m_tready = 1'b1;
        enable   = 1'b1;
        c = 0;
        while (fifo_rd_en == 4'b0 && c < 30) begin
            cyc(1);
            c++;
        end
        enable = 1'b0;
        p0 = rd_pulses;
        cyc(20);
        checks++;
        if (rd_pulses !== p0 + 1) begin
            errors++;
            $display("FAIL drop_pops: got %0d rd_en pulses, want %0d", rd_pulses, p0 + 1);
        end
        checks++;
        if (m_tvalid !== 1'b0 || fifo_rd_en !== 4'b0) begin
            errors++;
            $display("FAIL drop_idle: got tvalid=%b rd_en=%b, want 0/0000", m_tvalid, fifo_rd_en);
        end
        compare_words("drop", 1);
    endtask

    task automatic test_overflow();
        int c;
        do_reset();
        m_tready = 1'b1;
        full_vec = 4'b0100;
        enable   = 1'b1;
        c = 0;
        while (fifo_addr != 2'd2 && c < 40) begin
            cyc(1);
            c++;
        end
        cyc(1);
        full_vec = 4'b0;
        cyc(2);
        checks++;
        if (ovf_flags !== 4'b0100) begin
            errors++;
            $display("FAIL ovf_set: got %b, want 0100", ovf_flags);
        end
        clear_ovf = 1'b1;
        cyc(1);
        clear_ovf = 1'b0;
        checks++;
        if (ovf_flags !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear: got %b, want 0000", ovf_flags);
        end
        full_vec = 4'b0100;
        c = 0;
        while (fifo_addr != 2'd2 && c < 40) begin
            cyc(1);
            c++;
        end
        clear_ovf = 1'b1;
        cyc(1);
        clear_ovf = 1'b0;
        full_vec  = 4'b0;
        checks++;
        if (ovf_flags !== 4'b0100) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b, want 0100", ovf_flags);
        end
        enable = 1'b0;
        cyc(3);
    endtask

    task automatic test_async_reset();
        int c;
        do_reset();
        load(0, 12'h5A5);
        full_vec = 4'b0001;
        enable   = 1'b1;
        c = 0;
        while (!m_tvalid && c < 30) begin
            cyc(1);
            c++;
        end
        checks++;
        if (m_tvalid !== 1'b1 || ovf_flags !== 4'b0001) begin
            errors++;
            $display("FAIL areset_pre: got tvalid=%b ovf=%b, want 1/0001", m_tvalid, ovf_flags);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || fifo_rd_en !== 4'b0 || ovf_flags !== 4'b0) begin
            errors++;
            $display("FAIL areset_drop: got tvalid=%b rd_en=%b ovf=%b, want 0/0000/0000",
                     m_tvalid, fifo_rd_en, ovf_flags);
        end
        do_reset();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rd_pulses  = 0;
        underflows = 0;
        multi_hot  = 0;
        rstn       = 1'b0;
        enable     = 1'b0;
        clear_ovf  = 1'b0;
        m_tready   = 1'b0;
        full_vec   = 4'b0;
        for (int i = 0; i < 4; i++) begin
            wrp[i]    = 0;
            rdp[i]    = 0;
            tb_seq[i] = 8'd0;
        end
        test_reset();
        test_single_channel();
        test_burst();
        test_back_pressure();
        test_enable_drop();
        test_overflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
